// File: rtl/register_file_param.sv
// register_file_param: parameterised register file, one write port and two
// registered read ports with per-port valid flags.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read and a write
// to the same address on the same edge return the data being written.
module register_file_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [AW-1:0]    i_reg_write,
  input  logic [WIDTH-1:0] i_port_write,
  input  logic             i_write_enable,
  input  logic [AW-1:0]    i_reg_read_0,
  input  logic [AW-1:0]    i_reg_read_1,
  input  logic             i_read_en_0,
  input  logic             i_read_en_1,
  output logic [WIDTH-1:0] o_port_read_0,
  output logic [WIDTH-1:0] o_port_read_1,
  output logic             o_valid_0,
  output logic             o_valid_1
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             write_ok_c;
  logic [WIDTH-1:0] rd_data_0_c;
  logic [WIDTH-1:0] rd_data_1_c;

  // Value a read of addr sees at this edge, including bypass and zero register.
  function automatic logic [WIDTH-1:0] read_mux(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] val;
    val = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (i_write_enable && (i_reg_write == addr)) begin
      val = i_port_write;
    end
`endif
    if ((ZERO_REG != 0) && (addr == '0)) begin
      val = '0;
    end
    return val;
  endfunction

  // Write qualification: register 0 is read-only when hardwired to zero.
  always_comb begin
    write_ok_c = i_write_enable;
    if ((ZERO_REG != 0) && (i_reg_write == '0)) begin
      write_ok_c = 1'b0;
    end
  end

  // Read data selection for both ports.
  always_comb begin
    rd_data_0_c = read_mux(i_reg_read_0);
    rd_data_1_c = read_mux(i_reg_read_1);
  end

  // Register array storage with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok_c) begin
      regs[i_reg_write] <= i_port_write;
    end
  end

  // Read port 0 output register: load on request, otherwise hold data and drop valid.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_port_read_0 <= '0;
      o_valid_0     <= 1'b0;
    end else begin
      o_valid_0 <= i_read_en_0;
      if (i_read_en_0) begin
        o_port_read_0 <= rd_data_0_c;
      end
    end
  end

  // Read port 1 output register: load on request, otherwise hold data and drop valid.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_port_read_1 <= '0;
      o_valid_1     <= 1'b0;
    end else begin
      o_valid_1 <= i_read_en_1;
      if (i_read_en_1) begin
        o_port_read_1 <= rd_data_1_c;
      end
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param: two instances (4x4 plain and
// 8x8 with zero register) driven by the same stimulus, compared every cycle
// against an array-based model, plus directed scenarios with literal values.
module tb_register_file_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       en0, en1;
  logic [2:0] ra0, ra1;

  logic [3:0] a_rd0, a_rd1;
  logic       a_v0, a_v1;
  logic [7:0] b_rd0, b_rd1;
  logic       b_v0, b_v1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  register_file_param #(.WIDTH(4), .DEPTH(4), .ZERO_REG(0)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_reg_write(wa[1:0]), .i_port_write(wd[3:0]), .i_write_enable(we),
    .i_reg_read_0(ra0[1:0]), .i_reg_read_1(ra1[1:0]),
    .i_read_en_0(en0), .i_read_en_1(en1),
    .o_port_read_0(a_rd0), .o_port_read_1(a_rd1),
    .o_valid_0(a_v0), .o_valid_1(a_v1)
  );

  register_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_reg_write(wa), .i_port_write(wd), .i_write_enable(we),
    .i_reg_read_0(ra0), .i_reg_read_1(ra1),
    .i_read_en_0(en0), .i_read_en_1(en1),
    .o_port_read_0(b_rd0), .o_port_read_1(b_rd1),
    .o_valid_0(b_v0), .o_valid_1(b_v1)
  );

  // Reference model: [instance][index]
  logic [7:0] mem  [2][8];
  logic [7:0] m_rd [2][2];
  logic       m_v  [2][2];
  int         dep  [2] = '{4, 8};
  logic [7:0] msk  [2] = '{8'h0F, 8'hFF};
  bit         zr   [2] = '{1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
      for (int p = 0; p < 2; p++) begin
        m_rd[k][p] = 8'h00;
        m_v[k][p]  = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    int a, w;
    logic [7:0] v;
    for (int k = 0; k < 2; k++) begin
      w = int'(wa) % dep[k];
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? en0 : en1) begin
          a = int'((p == 0) ? ra0 : ra1) % dep[k];
          v = mem[k][a];
          if (BYP && we && (w == a)) v = wd & msk[k];
          if (zr[k] && (a == 0)) v = 8'h00;
          m_rd[k][p] = v;
          m_v[k][p]  = 1'b1;
        end else begin
          m_v[k][p] = 1'b0;
        end
      end
      if (we && !(zr[k] && (w == 0))) mem[k][w] = wd & msk[k];
    end
  endtask

  // Model update on every clock edge and on async reset assertion.
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else        model_edge();
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("a_rd0", {4'b0, a_rd0}, m_rd[0][0]);
      chk("a_rd1", {4'b0, a_rd1}, m_rd[0][1]);
      chk("a_v0",  a_v0, m_v[0][0]);
      chk("a_v1",  a_v1, m_v[0][1]);
      chk("b_rd0", b_rd0, m_rd[1][0]);
      chk("b_rd1", b_rd1, m_rd[1][1]);
      chk("b_v0",  b_v0, m_v[1][0]);
      chk("b_v1",  b_v1, m_v[1][1]);
    end
  end

  // Advance one clock; returns just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; en0 = 1'b0; en1 = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    idle(); we = 1'b1; wa = a; wd = d; step(); we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0; en0 = 1'b0; en1 = 1'b0; ra0 = '0; ra1 = '0;
    step(); step();
    chk("reset_rd0", {4'b0, a_rd0}, 8'h0);
    chk("reset_v0", a_v0, 1'b0);
    chk("reset_b_v1", b_v1, 1'b0);
    rst_n = 1'b1;
    step();

    // Reset then read every address on both ports
    for (int i = 0; i < 4; i++) begin
      en0 = 1'b1; ra0 = 3'(i); en1 = 1'b1; ra1 = 3'(3 - i);
      step();
      chk("rst_read_rd0", {4'b0, a_rd0}, 8'h0);
      chk("rst_read_v0", a_v0, 1'b1);
      chk("rst_read_rd1", {4'b0, a_rd1}, 8'h0);
      chk("rst_read_v1", a_v1, 1'b1);
    end

    // Write then read from both ports
    wr(3'd2, 8'h0A);
    en0 = 1'b1; ra0 = 3'd2; en1 = 1'b1; ra1 = 3'd2;
    step();
    chk("wr_rd_p0", {4'b0, a_rd0}, 8'h0A);
    chk("wr_rd_p1", {4'b0, a_rd1}, 8'h0A);
    chk("wr_rd_b_p1", b_rd1, 8'h0A);

    // Read during write to the same address
    wr(3'd1, 8'h03);
    we = 1'b1; wa = 3'd1; wd = 8'h05; en0 = 1'b1; ra0 = 3'd1;
    step();
    chk("rdw_same_edge", {4'b0, a_rd0}, BYP ? 8'h05 : 8'h03);
    idle(); en0 = 1'b1; ra0 = 3'd1;
    step();
    chk("rdw_next_read", {4'b0, a_rd0}, 8'h05);

    // Zero register on the 8x8 instance
    wr(3'd0, 8'hFF);
    en0 = 1'b1; ra0 = 3'd0;
    step();
    chk("zero_reg_read", b_rd0, 8'h00);
    chk("zero_reg_a_read", {4'b0, a_rd0}, 8'h0F);
    we = 1'b1; wa = 3'd0; wd = 8'h77; en0 = 1'b1; ra0 = 3'd0;
    step();
    chk("zero_reg_bypass", b_rd0, 8'h00);
    wr(3'd7, 8'h5A);
    en0 = 1'b1; ra0 = 3'd7;
    step();
    chk("reg7_read", b_rd0, 8'h5A);

    // Asynchronous reset between edges after a read request
    wr(3'd3, 8'h0C);
    en0 = 1'b1; ra0 = 3'd3;
    @(posedge clk); #2;
    chk("pre_reset_rd0", {4'b0, a_rd0}, 8'h0C);
    rst_n = 1'b0;
    #1;
    chk("async_rd0", {4'b0, a_rd0}, 8'h0);
    chk("async_v0", a_v0, 1'b0);
    chk("async_b_rd0", b_rd0, 8'h0);
    idle(); we = 1'b1; wa = 3'd1; wd = 8'h07;
    step(); step();
    idle(); rst_n = 1'b1;
    step();
    chk("post_release_v0", a_v0, 1'b0);
    en0 = 1'b1; ra0 = 3'd3; en1 = 1'b1; ra1 = 3'd1;
    step();
    chk("post_release_reg3", {4'b0, a_rd0}, 8'h0);
    chk("post_release_reg3_v", a_v0, 1'b1);
    chk("write_in_reset_ignored", {4'b0, a_rd1}, 8'h0);

    // Streaming back-to-back reads
    for (int i = 0; i < 4; i++) wr(3'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) begin
      en0 = 1'b1; ra0 = 3'(i);
      step();
      chk("stream_data", {4'b0, a_rd0}, 8'(i + 1));
      chk("stream_valid", a_v0, 1'b1);
    end
    en0 = 1'b0;
    step();
    chk("hold_valid_low", a_v0, 1'b0);
    chk("hold_data", {4'b0, a_rd0}, 8'h04);

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 3'($urandom_range(0, 7));
      wd  = 8'($urandom_range(0, 255));
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 3) != 0);
      ra0 = 3'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) wa = ra0;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
